// File: rtl/y86_pkg.sv
// Shared Y86-64 encoding constants, field payload and byte-select helper.
// The ENC_STRICT_FIELDS_EN build option is consumed by y86_instr_len.
package y86_pkg;

  localparam int unsigned NIB_W         = 4;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned WORD_W        = 64;
  localparam int unsigned LEN_W         = 4;
  localparam int unsigned CNT_W         = 32;
  localparam int unsigned INSTR_MAX_LEN = 10;

  localparam logic [NIB_W-1:0] I_HALT   = 4'h0;
  localparam logic [NIB_W-1:0] I_NOP    = 4'h1;
  localparam logic [NIB_W-1:0] I_RRMOVQ = 4'h2;
  localparam logic [NIB_W-1:0] I_IRMOVQ = 4'h3;
  localparam logic [NIB_W-1:0] I_RMMOVQ = 4'h4;
  localparam logic [NIB_W-1:0] I_MRMOVQ = 4'h5;
  localparam logic [NIB_W-1:0] I_OPQ    = 4'h6;
  localparam logic [NIB_W-1:0] I_JXX    = 4'h7;
  localparam logic [NIB_W-1:0] I_CALL   = 4'h8;
  localparam logic [NIB_W-1:0] I_RET    = 4'h9;
  localparam logic [NIB_W-1:0] I_PUSHQ  = 4'hA;
  localparam logic [NIB_W-1:0] I_POPQ   = 4'hB;

  localparam logic [NIB_W-1:0] REG_NONE = 4'hF;

  // OPq function codes
  localparam logic [NIB_W-1:0] A_ADD = 4'h0;
  localparam logic [NIB_W-1:0] A_SUB = 4'h1;
  localparam logic [NIB_W-1:0] A_AND = 4'h2;
  localparam logic [NIB_W-1:0] A_XOR = 4'h3;

  // jXX / cmovXX condition codes
  localparam logic [NIB_W-1:0] C_YES = 4'h0;
  localparam logic [NIB_W-1:0] C_LE  = 4'h1;
  localparam logic [NIB_W-1:0] C_L   = 4'h2;
  localparam logic [NIB_W-1:0] C_E   = 4'h3;
  localparam logic [NIB_W-1:0] C_NE  = 4'h4;
  localparam logic [NIB_W-1:0] C_GE  = 4'h5;
  localparam logic [NIB_W-1:0] C_G   = 4'h6;

  typedef enum logic {S_IDLE, S_EMIT} enc_state_e;

  typedef struct packed {
    logic [NIB_W-1:0]  icode;
    logic [NIB_W-1:0]  ifun;
    logic [NIB_W-1:0]  ra;
    logic [NIB_W-1:0]  rb;
    logic [WORD_W-1:0] valc;
  } instr_t;

  // Byte idx of the encoded instruction; valC starts after byte 0 or the register byte.
  function automatic logic [BYTE_W-1:0] enc_byte(input instr_t f, input logic has_regs,
                                                 input logic [LEN_W-1:0] idx);
    logic [BYTE_W-1:0] b;
    logic [LEN_W-1:0]  k;
    k = has_regs ? idx - 4'd2 : idx - 4'd1;
    b = 8'(f.valc >> (6'(k) * 6'd8));
    if (idx == 4'd0)
      b = {f.icode, f.ifun};
    else if (has_regs && idx == 4'd1)
      b = {f.ra, f.rb};
    return b;
  endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Combinational instruction classifier: length, layout flags and validity.
// ENC_STRICT_FIELDS_EN additionally rejects malformed ifun / register fields.
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [NIB_W-1:0] icode,
  input  logic [NIB_W-1:0] ifun,
  input  logic [NIB_W-1:0] rA,
  input  logic [NIB_W-1:0] rB,
  output logic [LEN_W-1:0] len,
  output logic             has_regs,
  output logic             has_valc,
  output logic             valid
);

  logic icode_ok;

  always_comb begin
    len      = '0;
    has_regs = 1'b0;
    has_valc = 1'b0;
    icode_ok = 1'b1;
    case (icode)
      I_HALT, I_NOP, I_RET: len = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
        len      = 4'd2;
        has_regs = 1'b1;
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        len      = 4'd10;
        has_regs = 1'b1;
        has_valc = 1'b1;
      end
      I_JXX, I_CALL: begin
        len      = 4'd9;
        has_valc = 1'b1;
      end
      default: icode_ok = 1'b0;
    endcase
  end

`ifdef ENC_STRICT_FIELDS_EN
  logic fields_ok;
  logic ra_set;
  logic rb_set;

  assign ra_set = (rA != REG_NONE);
  assign rb_set = (rB != REG_NONE);

  // Memory ops keep rB optional: rB = F means an absolute displacement.
  always_comb begin
    fields_ok = 1'b1;
    case (icode)
      I_RRMOVQ:           fields_ok = (ifun <= C_G) && ra_set && rb_set;
      I_JXX:              fields_ok = (ifun <= C_G);
      I_OPQ:              fields_ok = (ifun <= A_XOR) && ra_set && rb_set;
      I_IRMOVQ:           fields_ok = (ifun == 4'h0) && !ra_set && rb_set;
      I_RMMOVQ, I_MRMOVQ: fields_ok = (ifun == 4'h0) && ra_set;
      I_PUSHQ, I_POPQ:    fields_ok = (ifun == 4'h0) && ra_set && !rb_set;
      default:            fields_ok = (ifun == 4'h0);
    endcase
  end

  assign valid = icode_ok & fields_ok;
`else
  logic unused_fields;

  assign unused_fields = ^{ifun, rA, rB};
  assign valid         = icode_ok;
`endif

endmodule

// File: rtl/y86_instr_encoder.sv
// Serialises Y86-64 instruction fields into byte writes at the running write PC.
// Build option ENC_STRICT_FIELDS_EN tightens field validation in y86_instr_len.
module y86_instr_encoder
  import y86_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NIB_W-1:0]  icode,
  input  logic [NIB_W-1:0]  ifun,
  input  logic [NIB_W-1:0]  rA,
  input  logic [NIB_W-1:0]  rB,
  input  logic [WORD_W-1:0] valC,
  output logic              mem_we,
  input  logic              mem_wready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] pc,
  output logic [CNT_W-1:0]  instr_count,
  output logic              err_ins
);

  enc_state_e        state_q, state_d;
  logic [LEN_W-1:0]  idx_q, idx_d, len_q, len_d, idx_nxt;
  logic              has_regs_q, has_regs_d;
  instr_t            fld_q, fld_d, in_fld;
  logic              mem_we_d, err_d;
  logic [ADDR_W-1:0] mem_addr_d, pc_d;
  logic [BYTE_W-1:0] mem_wdata_d;
  logic [CNT_W-1:0]  count_d;

  logic [LEN_W-1:0]  in_len;
  logic              in_has_regs, in_has_valc, in_ok;
  logic              unused_has_valc;

  assign in_fld          = {icode, ifun, rA, rB, valC};
  assign idx_nxt         = idx_q + 4'd1;
  assign unused_has_valc = in_has_valc;

  // Held low through reset so the loader cannot hand over fields mid-reset.
  assign in_ready = rst_n & (state_q == S_IDLE);

  y86_instr_len u_len (
    .icode    (icode),
    .ifun     (ifun),
    .rA       (rA),
    .rB       (rB),
    .len      (in_len),
    .has_regs (in_has_regs),
    .has_valc (in_has_valc),
    .valid    (in_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      has_regs_q  <= 1'b0;
      fld_q       <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      pc          <= BASE_ADDR;
      instr_count <= '0;
      err_ins     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      has_regs_q  <= has_regs_d;
      fld_q       <= fld_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      pc          <= pc_d;
      instr_count <= count_d;
      err_ins     <= err_d;
    end
  end

  // Write-port outputs are registered, so each beat preloads the following byte.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    has_regs_d  = has_regs_q;
    fld_d       = fld_q;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    pc_d        = pc;
    count_d     = instr_count;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_ok) begin
            state_d     = S_EMIT;
            idx_d       = '0;
            len_d       = in_len;
            has_regs_d  = in_has_regs;
            fld_d       = in_fld;
            mem_we_d    = 1'b1;
            mem_addr_d  = pc;
            mem_wdata_d = enc_byte(in_fld, in_has_regs, 4'd0);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (mem_wready) begin
          if (idx_q == len_q - 4'd1) begin
            state_d  = S_IDLE;
            mem_we_d = 1'b0;
            pc_d     = pc + ADDR_W'(len_q);
            count_d  = instr_count + 32'd1;
          end else begin
            idx_d       = idx_nxt;
            mem_addr_d  = pc + ADDR_W'(idx_nxt);
            mem_wdata_d = enc_byte(fld_q, has_regs_q, idx_nxt);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/y86_instr_encoder.md
# y86_instr_encoder

Serialises decoded Y86-64 instruction fields (icode, ifun, rA, rB, valC) into the byte stream held in instruction memory, one byte per accepted beat at consecutive addresses. It is the write-side counterpart of the fetch stage: it produces the exact byte layout that fetch parses. It sits between the testbench/loader front end and the instruction memory write port, and advances an internal write PC by each instruction's length.

## Interface
- ADDR_W, 64, width of write address / PC
- BASE_ADDR, 0, PC value after reset
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept a new instruction
- icode  in  4  instruction code
- ifun  in  4  function code
- rA  in  4  register A (4'hF = none)
- rB  in  4  register B (4'hF = none)
- valC  in  64  constant / address / destination
- mem_we  out  1  byte write request
- mem_wready  in  1  memory accepts the byte this cycle
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  byte value
- pc  out  ADDR_W  address of the next instruction's first byte
- instr_count  out  32  instructions fully written
- err_ins  out  1  one-cycle pulse: rejected instruction

## Operation
- Lengths: halt 0 = 1, nop 1 = 1, rrmovq/cmovXX 2 = 2, irmovq 3 = 10, rmmovq 4 = 10, mrmovq 5 = 10, OPq 6 = 2, jXX 7 = 9, call 8 = 9, ret 9 = 1, pushq A = 2, popq B = 2. icode > 11 is invalid.
- Byte 0 = {icode, ifun}.
- Register byte {rA, rB} follows for icodes 2, 3, 4, 5, 6, A, B.
- valC follows, little-endian (valC[7:0] first), for icodes 3, 4, 5 (after the register byte) and 7, 8 (directly after byte 0).
- FSM states:
  - IDLE: in_ready = 1. On in_valid, latch the fields and byte count L, clear the byte index, go to EMIT. If the icode is invalid, pulse err_ins, write nothing, stay in IDLE, leave pc unchanged.
  - EMIT: mem_we = 1, mem_addr = pc + idx, mem_wdata = byte[idx]. The beat completes when mem_wready = 1; then idx++. On completion of beat L−1: pc += L, instr_count++, return to IDLE.
- mem_wready = 0 holds all outputs stable. Any number of stall cycles is allowed.
- Address arithmetic is modulo 2^ADDR_W: pc and mem_addr wrap silently. instr_count wraps at 2^32.
- Reset, including mid-instruction, abandons the partial instruction. Bytes already written stay in memory.
- Reset values: in_ready = 0 while rst_n is low, 1 after release; mem_we = 0; mem_addr = 0; mem_wdata = 0; pc = BASE_ADDR; instr_count = 0; err_ins = 0.

## Timing
- in_ready is a combinational decode of state == IDLE. Input fields are sampled only on the accept edge.
- First byte is driven the cycle after accept.
- Minimum L + 1 cycles per instruction: 1 accept cycle plus L beats. No accept in the same cycle as the last beat.
- pc and instr_count update on the edge completing the last beat. They are visible in the following IDLE cycle.
- err_ins asserts the cycle after the rejecting accept edge, for exactly one cycle.

## Configuration
- ENC_STRICT_FIELDS_EN defined:
  - Also rejected as invalid (err_ins, nothing written): nonzero ifun on icodes 0, 1, 3, 4, 5, 8, 9, A, B; ifun > 6 on icodes 2 and 7; ifun > 3 on icode 6.
  - Also rejected: rA ≠ F on irmovq; rB ≠ F on pushq/popq; rA = F or rB = F where a register is required.
- ENC_STRICT_FIELDS_EN undefined: only icode > 11 is rejected. All other fields are written verbatim.

## Structure
- Shared package y86_pkg:
  - icode constants I_HALT…I_POPQ
  - REG_NONE = 4'hF
  - ifun constants for OPq and jXX/cmov
  - INSTR_MAX_LEN = 10
- Sub-module y86_instr_len: combinational icode/ifun/rA/rB → {len[3:0], has_regs, has_valc, valid}. The strict checks under the macro live here.
- Top level holds the FSM, byte mux, pc and counter.

## Test plan
- Reset, then irmovq: icode 3, ifun 0, rA F, rB 2, valC 64'h0123456789ABCDEF, mem_wready always 1.
  - Bytes 30 F2 EF CD AB 89 67 45 23 01 at addresses 0–9.
  - pc = 10, instr_count = 1, in_ready low for exactly 10 cycles.
- jXX: icode 7, ifun 3, valC 64'h40, at pc 10.
  - Bytes 73 40 00 00 00 00 00 00 00 at addresses 10–18.
  - pc = 19.
- icode 4'hC presented in IDLE.
  - err_ins pulses once, mem_we never asserts, pc and instr_count unchanged.
- pushq rA 3 with mem_wready low for 3 cycles before each beat.
  - Bytes A0 3F written, outputs held stable during every stall.
  - Completion 8 cycles after accept.
- rst_n low after beat 4 of rmmovq, then release.
  - pc = BASE_ADDR, instr_count = 0, mem_we = 0, in_ready = 1 on the first cycle after release.
- With ENC_STRICT_FIELDS_EN: halt with ifun 1 → err_ins pulse, no write.
- Without the macro: the same halt → byte 01 written, pc += 1.
